rf_scoreboard: RTL and testbench

- Register-file hazard controller in the decode stage.
- Tracks in-flight writes per architectural register, stalls decode on RAW and on counter overflow, and gates the register file read enable.
- Retires entries on writeback; clears all state on pipeline flush.
- Sits between the decode issue point and the 32x32 register file. Drives its read enable, observes its write port.

---
 rtl/rf_scoreboard_pkg.sv | 20 ++
 rtl/rf_pending_counter.sv | 32 +++
 rtl/rf_scoreboard.sv | 97 +++++++++
 tb/tb_rf_scoreboard.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared decode-stage types for the register-file scoreboard.
// Holds register index types, architectural constants and the issue request bundle.
package rf_scoreboard_pkg;

  localparam int NUM_ARCH_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     use_rs1;
    logic     use_rs2;
    reg_idx_t rd;
    logic     we;
  } issue_req_t;

endpackage

// File: rtl/rf_pending_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// Simultaneous inc and dec cancel; clr wins over both.
module rf_pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic at_max
);

  logic [CNT_W-1:0] count;

  assign nonzero = (count != '0);
  assign at_max  = (count == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && nonzero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage register-file hazard controller: tracks in-flight writes per register,
// stalls issue on RAW, per-register saturation or global in-flight limit, and gates RF reads.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = NUM_ARCH_REGS,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 8,
  localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic [4:0]          issue_rd,
  input  logic                issue_we,
  output logic                issue_stall,
  output logic                issue_fire,
  output logic                rf_read_en,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic [INF_W-1:0]    inflight,
  output logic                err_wb_unexpected
);

  issue_req_t          req;
  logic [NUM_REGS-1:0] sat;
  logic                raw;
  logic                waw_sat;
  logic                full;
  logic                alloc;
  logic                ret;
  logic                wb_unexpected;

  assign req = '{rs1: issue_rs1, rs2: issue_rs2, use_rs1: issue_use_rs1,
                 use_rs2: issue_use_rs2, rd: issue_rd, we: issue_we};

  // RAW looks only at registered busy; a writeback this cycle does not bypass.
  assign raw = (req.use_rs1 && (req.rs1 != REG_ZERO) && busy[req.rs1]) ||
               (req.use_rs2 && (req.rs2 != REG_ZERO) && busy[req.rs2]);

  assign waw_sat = req.we && (req.rd != REG_ZERO) && sat[req.rd];
  assign full    = req.we && (req.rd != REG_ZERO) && (inflight == INF_W'(MAX_INFLIGHT));

  assign issue_stall = issue_valid && (raw || waw_sat || full);
  assign issue_fire  = issue_valid && !issue_stall;
  assign rf_read_en  = issue_fire;

  assign alloc         = issue_fire && req.we && (req.rd != REG_ZERO);
  assign ret           = wb_valid && (wb_rd != REG_ZERO) && busy[wb_rd];
  assign wb_unexpected = wb_valid && (wb_rd != REG_ZERO) && !busy[wb_rd];

  // x0 is hardwired zero, so it gets no counter and can never look busy.
  assign busy[0] = 1'b0;
  assign sat[0]  = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    rf_pending_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (alloc && (req.rd == reg_idx_t'(i))),
      .dec     (ret && (wb_rd == reg_idx_t'(i))),
      .clr     (flush),
      .nonzero (busy[i]),
      .at_max  (sat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else if (alloc && !ret) begin
      inflight <= inflight + INF_W'(1);
    end else if (ret && !alloc) begin
      inflight <= inflight - INF_W'(1);
    end
  end

  // Sticky until reset; flush does not hide a protocol error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_wb_unexpected <= 1'b0;
    end else if (wb_unexpected) begin
      err_wb_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0;
  logic [4:0]  issue_rs2 = '0;
  logic        issue_use_rs1 = 1'b0;
  logic        issue_use_rs2 = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_we = 1'b0;
  logic        issue_stall;
  logic        issue_fire;
  logic        rf_read_en;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] busy;
  logic [3:0]  inflight;
  logic        err_wb_unexpected;

  int checks = 0;
  int errors = 0;

  rf_scoreboard dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .issue_valid       (issue_valid),
    .issue_rs1         (issue_rs1),
    .issue_rs2         (issue_rs2),
    .issue_use_rs1     (issue_use_rs1),
    .issue_use_rs2     (issue_use_rs2),
    .issue_rd          (issue_rd),
    .issue_we          (issue_we),
    .issue_stall       (issue_stall),
    .issue_fire        (issue_fire),
    .rf_read_en        (rf_read_en),
    .wb_valid          (wb_valid),
    .wb_rd             (wb_rd),
    .flush             (flush),
    .busy              (busy),
    .inflight          (inflight),
    .err_wb_unexpected (err_wb_unexpected)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic we,
                               input logic wbv, input logic [4:0] wbrd, input logic fl);
    @(negedge clk);
    issue_valid   = v;
    issue_rs1     = rs1;
    issue_use_rs1 = u1;
    issue_rs2     = rs2;
    issue_use_rs2 = u2;
    issue_rd      = rd;
    issue_we      = we;
    wb_valid      = wbv;
    wb_rd         = wbrd;
    flush         = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic issueWrite(input logic [4:0] rd);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic writeBack(input logic [4:0] rd);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rd, 1'b0);
  endtask

  task automatic expectComb(input string tag, input logic stall, input logic fire);
    checkOutput({tag, ".stall"}, 32'(issue_stall), 32'(stall));
    checkOutput({tag, ".fire"}, 32'(issue_fire), 32'(fire));
    checkOutput({tag, ".rd_en"}, 32'(rf_read_en), 32'(fire));
  endtask

  task automatic expectState(input string tag, input logic [31:0] b, input logic [3:0] n, input logic e);
    checkOutput({tag, ".busy"}, busy, b);
    checkOutput({tag, ".inflight"}, 32'(inflight), 32'(n));
    checkOutput({tag, ".err"}, 32'(err_wb_unexpected), 32'(e));
  endtask

  initial begin
    // Reset: outputs idle with no issue presented.
    idle();
    idle();
    expectComb("reset", 1'b0, 1'b0);
    expectState("reset", 32'h0, 4'd0, 1'b0);
    rst_n = 1'b1;

    // Basic alloc, RAW stall held through the writeback cycle, then release.
    issueWrite(5'd5);
    expectComb("alloc5", 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    expectState("busy5", 32'h20, 4'd1, 1'b0);
    expectComb("raw5", 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    expectState("wb5", 32'h0, 4'd0, 1'b0);
    expectComb("raw5_clear", 1'b0, 1'b1);

    // x0 as destination and source; wb to x0 is not an error.
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    expectComb("x0", 1'b0, 1'b1);
    idle();
    expectState("x0", 32'h0, 4'd0, 1'b0);

    // Saturate x7 at 3 pending writes.
    issueWrite(5'd7);
    expectComb("x7_a", 1'b0, 1'b1);
    issueWrite(5'd7);
    expectComb("x7_b", 1'b0, 1'b1);
    issueWrite(5'd7);
    expectComb("x7_c", 1'b0, 1'b1);
    issueWrite(5'd7);
    expectState("x7_sat", 32'h80, 4'd3, 1'b0);
    expectComb("x7_sat", 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    expectComb("x7_sat_wb", 1'b1, 1'b0);
    issueWrite(5'd7);
    expectState("x7_after_wb", 32'h80, 4'd2, 1'b0);
    expectComb("x7_after_wb", 1'b0, 1'b1);
    issueWrite(5'd7);
    expectState("x7_resat", 32'h80, 4'd3, 1'b0);
    expectComb("x7_resat", 1'b1, 1'b0);
    writeBack(5'd7);
    writeBack(5'd7);
    writeBack(5'd7);
    idle();
    expectState("x7_drain", 32'h0, 4'd0, 1'b0);

    // Fill the global in-flight budget with x1..x8.
    for (int r = 1; r <= 8; r++) begin
      issueWrite(5'(r));
      expectComb($sformatf("fill%0d", r), 1'b0, 1'b1);
    end
    issueWrite(5'd9);
    expectState("full", 32'h1FE, 4'd8, 1'b0);
    expectComb("full_we", 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0);
    expectComb("full_nowe", 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0);
    expectComb("full_raw_rs2", 1'b1, 1'b0);
    for (int r = 1; r <= 4; r++) writeBack(5'(r));

    // Flush with a simultaneous alloc and retire discards everything.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 5'd5, 1'b1);
    expectState("pre_flush", 32'h1E0, 4'd4, 1'b0);
    expectComb("flush", 1'b0, 1'b1);
    idle();
    expectState("post_flush", 32'h0, 4'd0, 1'b0);

    // Alloc and retire on the same register cancel; unexpected wb is sticky.
    issueWrite(5'd9);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
    expectState("x9_one", 32'h200, 4'd1, 1'b0);
    expectComb("x9_same", 1'b0, 1'b1);
    idle();
    expectState("x9_same", 32'h200, 4'd1, 1'b0);
    writeBack(5'd12);
    idle();
    expectState("wb_unexp", 32'h200, 4'd1, 1'b1);
    writeBack(5'd9);
    idle();
    expectState("err_sticky", 32'h0, 4'd0, 1'b1);

    // Reset mid-operation clears state and the sticky error.
    issueWrite(5'd3);
    issueWrite(5'd4);
    expectState("pre_reset", 32'h8, 4'd1, 1'b1);
    rst_n = 1'b0;
    idle();
    expectState("mid_reset", 32'h0, 4'd0, 1'b0);
    rst_n = 1'b1;
    idle();
    expectComb("post_reset", 1'b0, 1'b0);
    expectState("post_reset", 32'h0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
